// File: rtl/rv32_alu_pkg.sv
// Shared definitions for the RV32I -> ALU issue path.
// Holds the ALU opcode encodings, the RV32I major opcodes and funct7 values
// the decoder recognises, the decoded-issue payload struct, and a helper that
// maps funct3 to the ALU opcode for the base (funct7 = 0) encodings.
package rv32_alu_pkg;

    localparam int unsigned RV_XLEN = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM_I_W = 12;
    localparam int unsigned IMM_U_W = 20;

    // ALU opcode encodings
    localparam logic [OP_W-1:0] ALU_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1100;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1101;

    // RV32I major opcodes handled by this stage
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    // funct7 / imm[11:5] qualifiers
    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    // Decoded operation as presented to the ALU/writeback side
    typedef struct packed {
        logic [RV_XLEN-1:0] in0;
        logic [RV_XLEN-1:0] in1;
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rd;
        logic               wb_en;
        logic               illegal;
    } alu_issue_t;

    // funct3 -> ALU opcode for the funct7 = 0000000 OP row (shared by OP-IMM)
    function automatic logic [OP_W-1:0] base_op(input logic [F3_W-1:0] f3);
        logic [OP_W-1:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational RV32I -> ALU translation.
// Ports:
//   instr    - RV32I instruction word
//   rs1_val  - rs1 register value
//   rs2_val  - rs2 register value
//   pc       - instruction address (AUIPC base)
//   dec_c    - decoded ALU operands, opcode, rd, writeback enable and
//              illegal flag (combinational)
module rv32_alu_decode
    import rv32_alu_pkg::*;
(
    input  logic [RV_XLEN-1:0] instr,
    input  logic [RV_XLEN-1:0] rs1_val,
    input  logic [RV_XLEN-1:0] rs2_val,
    input  logic [RV_XLEN-1:0] pc,
    output alu_issue_t         dec_c
);

    logic [OPC_W-1:0]   opc;
    logic [F3_W-1:0]    f3;
    logic [F7_W-1:0]    f7;
    logic [REG_W-1:0]   rd;
    logic [RV_XLEN-1:0] imm_i;
    logic [RV_XLEN-1:0] imm_u;
    logic [RV_XLEN-1:0] shamt;

    logic               legal;
    logic [OP_W-1:0]    op;
    logic [RV_XLEN-1:0] src_a;
    logic [RV_XLEN-1:0] src_b;

    // Instruction fields and immediates
    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{(RV_XLEN-IMM_I_W){instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], (RV_XLEN-IMM_U_W)'(0)};
    assign shamt = {(RV_XLEN-SHAMT_W)'(0), instr[24:20]};

    // Opcode/legality decode and natural operand order (a = first, b = second)
    always_comb begin
        legal = 1'b0;
        op    = ALU_NOP;
        src_a = rs1_val;
        src_b = rs2_val;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    legal = 1'b1;
                    op    = base_op(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    legal = 1'b1;
                    op    = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    legal = 1'b1;
                    op    = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                src_b = imm_i;
                case (f3)
                    3'b001: begin
                        src_b = shamt;
                        if (f7 == F7_BASE) begin
                            legal = 1'b1;
                            op    = ALU_SLL;
                        end
                    end
                    3'b101: begin
                        src_b = shamt;
                        if (f7 == F7_BASE) begin
                            legal = 1'b1;
                            op    = ALU_SRL;
                        end else if (f7 == F7_ALT) begin
                            legal = 1'b1;
                            op    = ALU_SRA;
                        end
                    end
                    default: begin
                        legal = 1'b1;
                        op    = base_op(f3);
                    end
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1;
                op    = ALU_ADD;
                src_a = '0;
                src_b = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op    = ALU_ADD;
                src_a = pc;
                src_b = imm_u;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Final payload; the ALU compares in0 > in1, so set-less-than swaps operands
    always_comb begin
        dec_c         = '0;
        dec_c.rd      = rd;
        dec_c.illegal = ~legal;
        if (legal) begin
            dec_c.op    = op;
            dec_c.wb_en = (rd != '0);
            if (op == ALU_SLT || op == ALU_SLTU) begin
                dec_c.in0 = src_b;
                dec_c.in1 = src_a;
            end else begin
                dec_c.in0 = src_a;
                dec_c.in1 = src_b;
            end
        end
    end

endmodule

// File: rtl/rv32_alu_issue.sv
// Decode/issue stage feeding the 32-bit ALU through a one-deep registered
// valid/ready slot.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush             - discard held and incoming instruction this cycle
//   in_valid/in_ready - upstream handshake (in_ready is combinational)
//   in_instr, in_rs1_val, in_rs2_val, in_pc - instruction and operands
//   out_valid/out_ready - downstream handshake
//   out_in0, out_in1, out_op, out_rd, out_wb_en, out_illegal - issued op
//   issue_count       - completed downstream handshakes (wrapping)
module rv32_alu_issue
    import rv32_alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,  // only 32 is supported
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_in0,
    output logic [XLEN-1:0]  out_in1,
    output logic [OP_W-1:0]  out_op,
    output logic [REG_W-1:0] out_rd,
    output logic             out_wb_en,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_count
);

    alu_issue_t       dec_c;
    alu_issue_t       issue_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             drain;

    rv32_alu_decode u_decode (
        .instr   (in_instr),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .pc      (in_pc),
        .dec_c   (dec_c)
    );

    // Slot can take a new op when empty or being drained, never during flush
    assign in_ready = ~flush & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = valid_q & out_ready & ~flush;

    // Issue slot: payload loads only on accept, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            issue_q <= dec_c;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    // Completed-issue counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (drain) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign out_valid   = valid_q;
    assign out_in0     = issue_q.in0;
    assign out_in1     = issue_q.in1;
    assign out_op      = issue_q.op;
    assign out_rd      = issue_q.rd;
    assign out_wb_en   = issue_q.wb_en;
    assign out_illegal = issue_q.illegal;
    assign issue_count = count_q;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Directed bench for rv32_alu_issue. The counter is built narrow (4 bits)
// so its all-ones and wrap cases are reachable in a short run.
module tb_rv32_alu_issue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [31:0] I_ADD      = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SLTI     = 32'hFFF32293; // slti x5,x6,-1
    localparam logic [31:0] I_SRAI_BAD = 32'h4210D093; // imm[11:5]=0100001
    localparam logic [31:0] I_SRAI31   = 32'h41F0D093; // srai x1,x1,31
    localparam logic [31:0] I_SLTU     = 32'h0062B233; // sltu x4,x5,x6
    localparam logic [31:0] I_MUL      = 32'h022081B3; // mul  (not ALU)
    localparam logic [31:0] I_LUI      = 32'h12345137; // lui  x2,0x12345
    localparam logic [31:0] I_OR       = 32'h0020E433; // or   x8,x1,x2
    localparam logic [31:0] I_AUIPC    = 32'h00001497; // auipc x9,0x1

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_instr = '0;
    logic [XLEN-1:0]  in_rs1_val = '0;
    logic [XLEN-1:0]  in_rs2_val = '0;
    logic [XLEN-1:0]  in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_in0;
    logic [XLEN-1:0]  out_in1;
    logic [3:0]       out_op;
    logic [4:0]       out_rd;
    logic             out_wb_en;
    logic             out_illegal;
    logic [CNT_W-1:0] issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_alu_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_in0     (out_in0),
        .out_in1     (out_in1),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en),
        .out_illegal (out_illegal),
        .issue_count (issue_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_pc      = pc;
    endtask

    task automatic check_out(input string tag, input logic [31:0] in0, input logic [31:0] in1,
                             input logic [3:0] op, input logic [4:0] rd,
                             input logic wb, input logic ill);
        check({tag, ".in0"},     out_in0, in0);
        check({tag, ".in1"},     out_in1, in1);
        check({tag, ".op"},      32'(out_op), 32'(op));
        check({tag, ".rd"},      32'(out_rd), 32'(rd));
        check({tag, ".wb_en"},   32'(out_wb_en), 32'(wb));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic check_vc(input string tag, input logic valid, input logic [31:0] cnt);
        check({tag, ".valid"}, 32'(out_valid), 32'(valid));
        check({tag, ".count"}, 32'(issue_count), cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        tick();
        tick();
        check_out("rst", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        check_vc("rst", 1'b0, 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Streamed decode with out_ready=1: one accept per cycle
        drive(I_ADD, 32'd5, 32'd7, 32'h0);
        tick();
        check_out("add", 32'd5, 32'd7, 4'h4, 5'd3, 1'b1, 1'b0);
        check_vc("add", 1'b1, 32'd0);

        drive(I_SLTI, 32'h8000_0000, 32'h0, 32'h0);
        tick();
        check_out("slti", 32'hFFFF_FFFF, 32'h8000_0000, 4'hC, 5'd5, 1'b1, 1'b0);
        check_vc("slti", 1'b1, 32'd1);

        drive(I_SRAI_BAD, 32'h0000_1234, 32'h0, 32'h0);
        tick();
        check_out("srai_bad", 32'h0, 32'h0, 4'h0, 5'd1, 1'b0, 1'b1);
        check_vc("srai_bad", 1'b1, 32'd2);

        drive(I_SRAI31, 32'hF000_0000, 32'h0, 32'h0);
        tick();
        check_out("srai31", 32'hF000_0000, 32'd31, 4'h7, 5'd1, 1'b1, 1'b0);

        drive(I_SLTU, 32'd3, 32'd9, 32'h0);
        tick();
        check_out("sltu", 32'd9, 32'd3, 4'hD, 5'd4, 1'b1, 1'b0);

        drive(I_MUL, 32'd5, 32'd7, 32'h0);
        tick();
        check_out("mul", 32'h0, 32'h0, 4'h0, 5'd3, 1'b0, 1'b1);
        check_vc("mul", 1'b1, 32'd5);

        drive(I_LUI, 32'h0000_DEAD, 32'h0000_BEEF, 32'h40);
        tick();
        check_out("lui", 32'h0, 32'h1234_5000, 4'h4, 5'd2, 1'b1, 1'b0);
        check_vc("lui", 1'b1, 32'd6);

        // Backpressure: LUI held for 3 cycles with a new instruction waiting
        out_ready = 1'b0;
        drive(I_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0);
        #1;
        check("bp.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("lui_hold", 32'h0, 32'h1234_5000, 4'h4, 5'd2, 1'b1, 1'b0);
            check_vc("lui_hold", 1'b1, 32'd6);
            check("lui_hold.in_ready", 32'(in_ready), 32'd0);
        end

        // Release together with a pending instruction: back-to-back transfer
        out_ready = 1'b1;
        #1;
        check("b2b.in_ready", 32'(in_ready), 32'd1);
        tick();
        check_out("or", 32'h0000_00F0, 32'h0000_000F, 4'h2, 5'd8, 1'b1, 1'b0);
        check_vc("or", 1'b1, 32'd7);

        // Flush while holding AUIPC with an incoming instruction
        drive(I_AUIPC, 32'h0, 32'h0, 32'h100);
        tick();
        check_out("auipc", 32'h100, 32'h1000, 4'h4, 5'd9, 1'b1, 1'b0);
        check_vc("auipc", 1'b1, 32'd8);
        out_ready = 1'b0;
        drive(I_ADD, 32'd1, 32'd1, 32'h0);
        tick();
        check_out("auipc_hold", 32'h100, 32'h1000, 4'h4, 5'd9, 1'b1, 1'b0);
        check_vc("auipc_hold", 1'b1, 32'd8);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush.in_ready", 32'(in_ready), 32'd0);
        tick();
        check_vc("flush", 1'b0, 32'd8);
        flush = 1'b0;

        // Fill counter to all-ones, holding the last op, then reset mid-hold
        for (int i = 0; i < 8; i++) begin
            drive(I_ADD, 32'(i), 32'd1, 32'h0);
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check_out("full_hold", 32'd7, 32'd1, 4'h4, 5'd3, 1'b1, 1'b0);
        check_vc("full_hold", 1'b1, 32'hF);
        rst = 1'b1;
        tick();
        check_out("rst2", 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
        check_vc("rst2", 1'b0, 32'd0);
        rst = 1'b0;

        // Counter wrap: 16 completed handshakes from zero
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(I_ADD, 32'(i), 32'd2, 32'h0);
            tick();
        end
        check_vc("pre_wrap", 1'b1, 32'hF);
        in_valid = 1'b0;
        tick();
        check_vc("wrap", 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
